// File: rtl/tx_uart.sv
// tx_uart: UART transmitter, start + DATA_BITS (LSB first) + optional even parity + stop, paced by 16x baud ticks.
// Optional feature: define TX_PARITY_EN to insert an even-parity bit between the last data bit and the stop bit.
module tx_uart #(
    parameter int DATA_BITS = 8,
    parameter int N_TICKS   = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_ticks,
    input  logic                 i_tx_start,
    input  logic [DATA_BITS-1:0] i_data_in,
    output logic                 o_tx,
    output logic                 o_tx_busy,
    output logic                 o_tx_done
);
    // The tick counter is shared by every state, so it is widened when the stop period exceeds 16 ticks.
    localparam int CW = (N_TICKS > 16) ? $clog2(N_TICKS) : 4;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(15);
    localparam logic [CW-1:0] STOP_LAST = CW'(N_TICKS - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   tx_q, tx_d;
    logic                   done;
`ifdef TX_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    // State, counters, shift register and the registered line value.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
`ifdef TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
`ifdef TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Next-state logic; the line value is derived from the current state and registered one cycle later.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = 1'b1;
        done     = 1'b0;
`ifdef TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_tx_start) begin
                    state_d  = START;
                    shift_d  = i_data_in;
                    cnt_d    = '0;
                    bit_d    = '0;
`ifdef TX_PARITY_EN
                    parity_d = ^i_data_in;
`endif
                end
            end
            START: begin
                tx_d = 1'b0;
                if (i_ticks) begin
                    cnt_d = (cnt_q == BIT_LAST) ? '0 : cnt_q + 1'b1;
                    if (cnt_q == BIT_LAST) begin
                        state_d = DATA;
                        bit_d   = '0;
                    end
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (i_ticks) begin
                    cnt_d = (cnt_q == BIT_LAST) ? '0 : cnt_q + 1'b1;
                    if (cnt_q == BIT_LAST) begin
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == DATA_LAST) begin
`ifdef TX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end
                end
            end
`ifdef TX_PARITY_EN
            PARITY: begin
                tx_d = parity_q;
                if (i_ticks) begin
                    cnt_d = (cnt_q == BIT_LAST) ? '0 : cnt_q + 1'b1;
                    if (cnt_q == BIT_LAST) state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (i_ticks) begin
                    cnt_d = (cnt_q == STOP_LAST) ? '0 : cnt_q + 1'b1;
                    if (cnt_q == STOP_LAST) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_tx      = tx_q;
    assign o_tx_busy = (state_q != IDLE);
    assign o_tx_done = done;
endmodule
